// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the MEM stage and a registered word-wide data memory.
// Latency: error 1, SW 2, load 3, SB/SH read-modify-write 4 cycles from accept to resp_valid.
// Backpressure: one request in flight; req_ready only in IDLE, stall high whenever not IDLE.
module dmem_lsu_ctrl #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;

    // Request fields latched at accept; only the low halfword of store data is
    // needed after accept because full-word store data goes straight to wword_q.
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    // Word presented on mem_wdata: raw store data for SW, merged word for SB/SH.
    logic [31:0] wword_q;

    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic        accept;
    logic        req_err;
    logic        req_is_sw;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept    = (state_q == S_IDLE) && req_valid;
    assign req_is_sw = req_store && (req_funct3 == F3_W);

    // Classify the incoming request: alignment, unsupported funct3, range.
    always_comb begin
        req_err = 1'b0;
        if (req_store) begin
            if (req_funct3 >= 3'b011) begin
                req_err = 1'b1;
            end else if ((req_funct3 == F3_H) && req_addr[0]) begin
                req_err = 1'b1;
            end else if ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00)) begin
                req_err = 1'b1;
            end
        end else begin
            unique case (req_funct3)
                F3_B, F3_BU: req_err = 1'b0;
                F3_H, F3_HU: req_err = req_addr[0];
                F3_W:        req_err = (req_addr[1:0] != 2'b00);
                default:     req_err = 1'b1;
            endcase
        end
        if ({2'b00, req_addr[31:2]} >= MEM_WORDS_U) begin
            req_err = 1'b1;
        end
    end

    // Lane selection and extension of the word returned by memory.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (funct3_q)
            F3_B:    load_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    load_ext = {{16{rd_half[15]}}, rd_half};
            F3_BU:   load_ext = {24'h000000, rd_byte};
            F3_HU:   load_ext = {16'h0000, rd_half};
            default: load_ext = mem_rdata;
        endcase
    end

    // Merge sub-word store data into the word just read; other lanes keep old data.
    always_comb begin
        merged = mem_rdata;
        if (funct3_q == F3_B) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else if (funct3_q == F3_H) begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // State register; reset aborts any access in flight on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: errors skip memory, SW skips the read, SB/SH do read-modify-write.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err) begin
                        state_d = S_DONE;
                    end else if (req_is_sw) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_CAPT;
            S_CAPT:  state_d = store_q ? S_WRITE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; address and data come from registers
    // so they stay constant from READ through WRITE.
    always_comb begin
        req_ready  = (state_q == S_IDLE) && !rst;
        stall      = (state_q != S_IDLE);
        resp_valid = (state_q == S_DONE);
        mem_req    = (state_q == S_READ) || (state_q == S_WRITE);
        mem_we     = (state_q == S_WRITE);
        mem_addr   = {2'b00, addr_q[31:2]};
        mem_wdata  = wword_q;
        resp_err   = resp_err_q;
        resp_rdata = resp_rdata_q;
    end

    // Request capture, write-word build and response registers (updated only on
    // the edge entering DONE, so they hold between responses).
    always_ff @(posedge clk) begin
        if (rst) begin
            store_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            wdata_q      <= 16'h0;
            wword_q      <= 32'h0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata[15:0];
                wword_q  <= req_wdata;
                if (req_err) begin
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= 32'h0;
                end
            end
            if (state_q == S_CAPT) begin
                if (store_q) begin
                    wword_q <= merged;
                end else begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_ext;
                end
            end
            if (state_q == S_WRITE) begin
                resp_err_q   <= 1'b0;
                resp_rdata_q <= 32'h0;
            end
        end
    end

endmodule
